// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Optional macro MULTDIV_EARLY_ZERO_EN: zero-result operations complete on the start edge.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [31:0]      ir_in,
  output logic [WIDTH-1:0] result,
  output logic             result_rdy,
  output logic             exception,
  output logic             busy,
  output logic [31:0]      ir_out
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (WIDTH'(0) - v) : v;
  endfunction

  // Returns {exception, result}: overflow when the signed product needs more than WIDTH bits.
  function automatic logic [WIDTH:0] mul_sat(input logic [2*WIDTH-1:0] pmag, input logic neg);
    logic [2*WIDTH-1:0] p;
    p = neg ? ((2*WIDTH)'(0) - pmag) : pmag;
    return {(p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}}), p[WIDTH-1:0]};
  endfunction

  // Returns {exception, result}: divide-by-zero, or a positive quotient of 2^(WIDTH-1).
  function automatic logic [WIDTH:0] div_sat(input logic [WIDTH-1:0] q, input logic neg,
                                             input logic dz);
    logic [WIDTH-1:0] r;
    r = neg ? (WIDTH'(0) - q) : q;
    if (dz) return {1'b1, {WIDTH{1'b0}}};
    return {(!neg && q[WIDTH-1]), r};
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] am_q, am_d, bm_q, bm_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic [31:0]      irp_q, irp_d, ir_q, ir_d;

  logic [WIDTH:0]   msum, dshift, ddiff;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             start, early_zero;

  // Single iteration step for whichever operation is in flight.
  always_comb begin
    msum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? am_q : {WIDTH{1'b0}})};
    dshift = {hi_q, lo_q[WIDTH-1]};
    ddiff  = dshift - {1'b0, bm_q};
    hi_n   = hi_q;
    lo_n   = lo_q;
    if (state_q == MULT) begin
      hi_n = msum[WIDTH:1];
      lo_n = {msum[0], lo_q[WIDTH-1:1]};
    end else if (state_q == DIV) begin
      hi_n = ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ~ddiff[WIDTH]};
    end
  end

  always_comb begin
    start = ctrl_MULT || ctrl_DIV;
`ifdef MULTDIV_EARLY_ZERO_EN
    early_zero = ctrl_MULT ? (operand_A == '0 || operand_B == '0)
                           : (operand_A == '0 && operand_B != '0);
`else
    early_zero = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    am_d     = am_q;
    bm_d     = bm_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    exc_d    = exc_q;
    irp_d    = irp_q;
    ir_d     = ir_q;
    case (state_q)
      MULT, DIV: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          ir_d    = irp_q;
          if (state_q == MULT) {exc_d, result_d} = mul_sat({hi_n, lo_n}, neg_q);
          else                 {exc_d, result_d} = div_sat(lo_n, neg_q, bm_q == '0);
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = ctrl_MULT ? MULT : DIV;
          am_d    = mag(operand_A);
          bm_d    = mag(operand_B);
          neg_d   = operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = ctrl_MULT ? mag(operand_B) : mag(operand_A);
          irp_d   = ir_in;
          if (early_zero) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b0;
            ir_d     = ir_in;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      am_q     <= '0;
      bm_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      irp_q    <= '0;
      ir_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      am_q     <= am_d;
      bm_q     <= bm_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      irp_q    <= irp_d;
      ir_q     <= ir_d;
    end
  end

  assign result     = result_q;
  assign exception  = exc_q;
  assign ir_out     = ir_q;
  assign result_rdy = (state_q == DONE);
  assign busy       = (state_q == MULT) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, signed results, exceptions, hazards, reset abort.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] operand_A, operand_B, ir_in;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] result, ir_out;
  logic        result_rdy, exception, busy;

  int n_pass  = 0;
  int n_total = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .operand_A(operand_A), .operand_B(operand_B),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .ir_in(ir_in), .result(result),
    .result_rdy(result_rdy), .exception(exception), .busy(busy), .ir_out(ir_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Call at a negedge; the next posedge is the start edge.
  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] ir,
                        input int disturb, input logic [31:0] exp_res, input logic exp_exc,
                        input int exp_lat, input int exp_busy);
    int lat, bcnt;
    lat = -1;
    bcnt = 0;
    operand_A = a; operand_B = b; ir_in = ir;
    ctrl_MULT = m; ctrl_DIV = d;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (result_rdy) begin
        lat = cyc;
        break;
      end
      if (cyc == disturb) begin
        ctrl_DIV = 1'b1; ctrl_MULT = 1'b1;
        operand_A = 32'd5; operand_B = 32'd9; ir_in = 32'hDEADBEEF;
      end else if (cyc == disturb + 1) begin
        ctrl_DIV = 1'b0; ctrl_MULT = 1'b0;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy cycles"}, bcnt, exp_busy);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " exception"}, exception, exp_exc);
    chk({tag, " ir_out"}, ir_out, ir);
    chk({tag, " busy in done"}, busy, 1'b0);
  endtask

  initial begin
    int rdy_seen;
    reset = 1'b1;
    operand_A = '0; operand_B = '0; ir_in = '0;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset result", result, 0);
    chk("reset rdy", result_rdy, 0);
    chk("reset exc", exception, 0);
    chk("reset busy", busy, 0);
    chk("reset ir_out", ir_out, 0);
    reset = 1'b0;
    @(negedge clock);

    run_op("mul 6*7", 1, 0, 32'd6, 32'd7, 32'h12345678, 0, 32'd42, 0, 33, 32);
    @(negedge clock);
    chk("idle rdy low", result_rdy, 0);
    chk("idle result hold", result, 32'd42);
    chk("idle ir hold", ir_out, 32'h12345678);

    run_op("mul -3*5", 1, 0, -32'sd3, 32'd5, 32'h1, 0, 32'hFFFFFFF1, 0, 33, 32);
    @(negedge clock);
    run_op("mul ovf", 1, 0, 32'h00010000, 32'h00010000, 32'h2, 0, 32'h0, 1, 33, 32);
    @(negedge clock);
    run_op("mul minneg*1", 1, 0, 32'h80000000, 32'd1, 32'h3, 0, 32'h80000000, 0, 33, 32);
    @(negedge clock);
    run_op("mul minneg*-1", 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h4, 0, 32'h80000000, 1, 33, 32);
    @(negedge clock);
    run_op("div 100/7", 0, 1, 32'd100, 32'd7, 32'h5, 0, 32'd14, 0, 33, 32);
    @(negedge clock);
    run_op("div -7/2", 0, 1, -32'sd7, 32'd2, 32'h6, 0, 32'hFFFFFFFD, 0, 33, 32);
    @(negedge clock);
    run_op("div 5/0", 0, 1, 32'd5, 32'd0, 32'h7, 0, 32'h0, 1, 33, 32);
    @(negedge clock);
    run_op("div minneg/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h8, 0, 32'h80000000, 1, 33, 32);
    @(negedge clock);
    run_op("div minneg/2", 0, 1, 32'h80000000, 32'd2, 32'h9, 0, 32'hC0000000, 0, 33, 32);
    @(negedge clock);
    run_op("div 7/-7", 0, 1, 32'd7, 32'hFFFFFFF9, 32'hA, 0, 32'hFFFFFFFF, 0, 33, 32);
    @(negedge clock);
    run_op("mul disturbed", 1, 0, 32'd1000, 32'd1000, 32'hB, 10, 32'd1000000, 0, 33, 32);
    // Start issued during the DONE cycle of the previous op.
    run_op("div back2back", 0, 1, 32'd100, 32'd7, 32'hC, 0, 32'd14, 0, 33, 32);
    @(negedge clock);
    run_op("both pulses", 1, 1, 32'd6, 32'd7, 32'hD, 0, 32'd42, 0, 33, 32);

    // Abort a divide with reset on its 15th busy cycle.
    @(negedge clock);
    operand_A = 32'd100; operand_B = 32'd3; ir_in = 32'hE;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort result", result, 0);
    chk("abort rdy", result_rdy, 0);
    chk("abort exc", exception, 0);
    chk("abort busy", busy, 0);
    chk("abort ir_out", ir_out, 0);
    reset = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (result_rdy || busy) rdy_seen++;
    end
    chk("abort no rdy", rdy_seen, 0);
    run_op("mul after abort", 1, 0, 32'd2, 32'd3, 32'hF, 0, 32'd6, 0, 33, 32);

    @(negedge clock);
`ifdef MULTDIV_EARLY_ZERO_EN
    run_op("mul 0*9", 1, 0, 32'd0, 32'd9, 32'h10, 0, 32'd0, 0, 1, 0);
`else
    run_op("mul 0*9", 1, 0, 32'd0, 32'd9, 32'h10, 0, 32'd0, 0, 33, 32);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
